// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller with BCD countdown and night flash.
// Ports:
//   iCLK       system clock
//   iRST       synchronous active-high reset
//   iNIGHT     night mode request (level)
//   oNS_LIGHT  north/south lamps {R,Y,G}
//   oEW_LIGHT  east/west lamps {R,Y,G}
//   oTENS      BCD tens digit of seconds left
//   oONES      BCD ones digit of seconds left
//   oSEC_TICK  one-cycle pulse on each second update
module traffic_light_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iNIGHT,
  output logic [2:0] oNS_LIGHT,
  output logic [2:0] oEW_LIGHT,
  output logic [3:0] oTENS,
  output logic [3:0] oONES,
  output logic       oSEC_TICK
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);

  localparam logic [3:0] G_TENS =
    4'(GREEN_T / 10);
  localparam logic [3:0] G_ONES =
    4'(GREEN_T % 10);
  localparam logic [3:0] Y_TENS =
    4'(YELLOW_T / 10);
  localparam logic [3:0] Y_ONES =
    4'(YELLOW_T % 10);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW,
    NIGHT
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          flash;
  logic          tick;
  logic          last_sec;

  assign tick     = (presc == PMAX);
  assign last_sec = (oTENS == 4'd0) &&
                    (oONES == 4'd1);

  function automatic state_t nxt(
    input state_t s
  );
    case (s)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      default:   nxt = NS_GREEN;
    endcase
  endfunction

  function automatic logic is_green(
    input state_t s
  );
    is_green = (s == NS_GREEN) ||
               (s == EW_GREEN);
  endfunction

  function automatic logic [2:0] ns_lamp(
    input state_t s
  );
    case (s)
      NS_GREEN:  ns_lamp = L_GRN;
      NS_YELLOW: ns_lamp = L_YEL;
      default:   ns_lamp = L_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(
    input state_t s
  );
    case (s)
      EW_GREEN:  ew_lamp = L_GRN;
      EW_YELLOW: ew_lamp = L_YEL;
      default:   ew_lamp = L_RED;
    endcase
  endfunction

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= NS_GREEN;
      presc     <= '0;
      flash     <= 1'b0;
      oTENS     <= G_TENS;
      oONES     <= G_ONES;
      oNS_LIGHT <= L_GRN;
      oEW_LIGHT <= L_RED;
      oSEC_TICK <= 1'b0;
    end else if (iNIGHT && state != NIGHT) begin
      // Night entry restarts the second so
      // the first flash period is full length.
      state     <= NIGHT;
      presc     <= '0;
      flash     <= 1'b1;
      oTENS     <= 4'd0;
      oONES     <= 4'd0;
      oNS_LIGHT <= L_YEL;
      oEW_LIGHT <= L_YEL;
      oSEC_TICK <= 1'b0;
    end else if (!iNIGHT && state == NIGHT) begin
      state     <= NS_GREEN;
      presc     <= '0;
      flash     <= 1'b0;
      oTENS     <= G_TENS;
      oONES     <= G_ONES;
      oNS_LIGHT <= L_GRN;
      oEW_LIGHT <= L_RED;
      oSEC_TICK <= 1'b0;
    end else begin
      oSEC_TICK <= tick;
      presc     <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (state == NIGHT) begin
          flash     <= ~flash;
          oNS_LIGHT <= {1'b0, ~flash, 1'b0};
          oEW_LIGHT <= {1'b0, ~flash, 1'b0};
        end else if (last_sec) begin
          // Counter never shows 00 in a
          // normal phase: 01 is the last second.
          state     <= nxt(state);
          oNS_LIGHT <= ns_lamp(nxt(state));
          oEW_LIGHT <= ew_lamp(nxt(state));
          if (is_green(nxt(state))) begin
            oTENS <= G_TENS;
            oONES <= G_ONES;
          end else begin
            oTENS <= Y_TENS;
            oONES <= Y_ONES;
          end
        end else if (oONES == 4'd0) begin
          oONES <= 4'd9;
          oTENS <= oTENS - 4'd1;
        end else begin
          oONES <= oONES - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl.
// Directed plan followed by random night/reset traffic.
module tb_traffic_light_ctrl;

  localparam int D = 4;
  localparam int G = 12;
  localparam int Y = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       night = 1'b0;
  logic [2:0] ns_l;
  logic [2:0] ew_l;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       stick;

  int vectors = 0;
  int miscompares = 0;

  int m_ph, m_rem, m_cnt;
  bit m_night, m_flash, m_tick;

  traffic_light_ctrl #(
    .TICK_DIV(D),
    .GREEN_T (G),
    .YELLOW_T(Y)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iNIGHT   (night),
    .oNS_LIGHT(ns_l),
    .oEW_LIGHT(ew_l),
    .oTENS    (tens),
    .oONES    (ones),
    .oSEC_TICK(stick)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic bound_chk(
    input string tag,
    input bit    ok
  );
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL %s got=timeout exp=event",
             tag);
    end
  endtask

  function automatic logic [2:0] exp_ns();
    if (m_night) return {1'b0, m_flash, 1'b0};
    case (m_ph)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew();
    if (m_night) return {1'b0, m_flash, 1'b0};
    case (m_ph)
      2:       return 3'b001;
      3:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Phase index 0..3 = NSG,NSY,EWG,EWY;
  // m_rem is whole seconds left as an integer.
  task automatic model_edge();
    if (rst) begin
      m_ph = 0; m_rem = G; m_cnt = 0;
      m_night = 0; m_flash = 0; m_tick = 0;
    end else if (night && !m_night) begin
      m_night = 1; m_cnt = 0;
      m_flash = 1; m_rem = 0; m_tick = 0;
    end else if (!night && m_night) begin
      m_night = 0; m_ph = 0; m_rem = G;
      m_cnt = 0; m_tick = 0;
    end else begin
      m_tick = (m_cnt == D - 1);
      m_cnt = m_tick ? 0 : m_cnt + 1;
      if (m_tick) begin
        if (m_night) begin
          m_flash = !m_flash;
        end else if (m_rem == 1) begin
          m_ph = (m_ph + 1) % 4;
          m_rem = (m_ph % 2 == 0) ? G : Y;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("ns", {1'b0, ns_l}, {1'b0, exp_ns()});
    chk("ew", {1'b0, ew_l}, {1'b0, exp_ew()});
    chk("tens", tens, 4'(m_rem / 10));
    chk("ones", ones, 4'(m_rem % 10));
    chk("tick", {3'b0, stick}, {3'b0, m_tick});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic chk_digits(
    input string tag,
    input int    t,
    input int    o
  );
    chk({tag, "_tens"}, tens, 4'(t));
    chk({tag, "_ones"}, ones, 4'(o));
  endtask

  initial begin
    int tk;
    bit ok;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_ns", {1'b0, ns_l}, 4'b0001);
    chk("rst_ew", {1'b0, ew_l}, 4'b0100);
    chk_digits("rst", 1, 2);
    chk("rst_tick", {3'b0, stick}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pre_tick", {3'b0, stick}, 4'd0);
    end
    step();
    chk("first_tick", {3'b0, stick}, 4'd1);
    chk_digits("first", 1, 1);

    // Borrow and full cycle
    tk = 1;
    for (int i = 0; i < 116; i++) begin
      step();
      if (m_tick) begin
        tk++;
        if (tk == 2) chk_digits("t2", 1, 0);
        if (tk == 3) chk_digits("borrow", 0, 9);
        if (tk == 12) begin
          chk("t12_ns", {1'b0, ns_l}, 4'b0010);
          chk_digits("t12", 0, 3);
        end
        if (tk == 15) begin
          chk("t15_ns", {1'b0, ns_l}, 4'b0100);
          chk("t15_ew", {1'b0, ew_l}, 4'b0001);
          chk_digits("t15", 1, 2);
        end
        if (tk == 27)
          chk("t27_ew", {1'b0, ew_l}, 4'b0010);
        if (tk == 30) begin
          chk("t30_ns", {1'b0, ns_l}, 4'b0001);
          chk_digits("t30", 1, 2);
        end
      end
    end
    bound_chk("tick_count", tk == 30);

    // Night mode at 0/7
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = (m_rem == 7) && !m_night;
    end
    bound_chk("reach_07", ok);
    chk_digits("at07", 0, 7);
    night = 1'b1;
    step();
    chk("n_ns", {1'b0, ns_l}, 4'b0010);
    chk("n_ew", {1'b0, ew_l}, 4'b0010);
    chk_digits("n", 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("n_off", {1'b0, ns_l}, 4'b0000);
    chk("n_off_ew", {1'b0, ew_l}, 4'b0000);
    for (int i = 0; i < 4; i++) step();
    chk("n_on", {1'b0, ns_l}, 4'b0010);
    night = 1'b0;
    step();
    chk("nx_ns", {1'b0, ns_l}, 4'b0001);
    chk("nx_ew", {1'b0, ew_l}, 4'b0100);
    chk_digits("nx", 1, 2);
    chk("nx_tick", {3'b0, stick}, 4'd0);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("nx_first", {3'b0, stick}, 4'd1);
    chk_digits("nx_first", 1, 1);

    // Night on a tick cycle
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      ok = (m_cnt == D - 1);
    end
    bound_chk("reach_tickcyc", ok);
    night = 1'b1;
    step();
    chk("sim_tick", {3'b0, stick}, 4'd0);
    chk("sim_ns", {1'b0, ns_l}, 4'b0010);
    chk_digits("sim", 0, 0);
    night = 1'b0;
    step();

    // Reset with night during EW_YELLOW
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = (m_ph == 3) && !m_night;
    end
    bound_chk("reach_ewy", ok);
    chk("ewy_ew", {1'b0, ew_l}, 4'b0010);
    rst = 1'b1;
    night = 1'b1;
    step();
    chk("rn_ns", {1'b0, ns_l}, 4'b0001);
    chk("rn_ew", {1'b0, ew_l}, 4'b0100);
    chk_digits("rn", 1, 2);
    chk("rn_tick", {3'b0, stick}, 4'd0);
    rst = 1'b0;
    night = 1'b0;

    // Random night/reset traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        night = ~night;
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
